// File: rtl/matrix_operand_loader_if.sv
// Element-in / packed-frame-out stream bundle for the matrix operand loader.
// The master drives elements and consumes frames; the slave is the loader.
interface matrix_operand_loader_if #(
  parameter int ELEM_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_a;
  logic [7:0]        out_b;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Collects eight 2-bit elements into shadow slots, range-checks them and
// presents each legal frame as packed A/B operands on a valid/ready output.
module matrix_operand_loader #(
  parameter int ELEM_W  = 2,
  parameter int MAX_VAL = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  matrix_operand_loader_if.slave  bus,
  output logic                    frame_err_o,
  output logic [3:0]              elem_count_o
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [ELEM_W-1:0] MAX_V     = ELEM_W'(MAX_VAL);
  localparam logic [3:0]        LAST_SLOT = 4'd7;
  localparam logic [3:0]        FULL_CNT  = 4'd8;

  logic [0:0]        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              bad_q, bad_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        out_a_q, out_a_d;
  logic [7:0]        out_b_q, out_b_d;
  logic [ELEM_W-1:0] shadow_q [8];
  logic [ELEM_W-1:0] shadow_d [8];

  logic accept;
  logic transfer;
  logic elem_bad;
  logic bad_next;

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign frame_err_o   = frame_err_q;
  assign elem_count_o  = count_q;

  assign accept   = bus.in_valid && (state_q == ST_LOAD);
  assign transfer = out_valid_q && bus.out_ready;
  assign elem_bad = (bus.in_data > MAX_V);
  // The 8th element's own range check must count toward the frame verdict.
  assign bad_next = bad_q || elem_bad;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bad_d       = bad_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    for (int i = 0; i < 8; i++) begin
      shadow_d[i] = shadow_q[i];
    end

    if (flush_i) begin
      state_d     = ST_LOAD;
      count_d     = '0;
      bad_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            shadow_d[count_q[2:0]] = bus.in_data;
            if (count_q == LAST_SLOT) begin
              bad_d = 1'b0;
              if (bad_next) begin
                frame_err_d = 1'b1;
                count_d     = '0;
              end else begin
                out_a_d     = {shadow_d[3], shadow_d[2], shadow_d[1], shadow_d[0]};
                out_b_d     = {shadow_d[7], shadow_d[6], shadow_d[5], shadow_d[4]};
                out_valid_d = 1'b1;
                count_d     = FULL_CNT;
                state_d     = ST_HOLD;
              end
            end else begin
              bad_d   = bad_next;
              count_d = count_q + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (transfer) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            state_d     = ST_LOAD;
          end
        end
        default: begin
          state_d     = ST_LOAD;
          count_d     = '0;
          bad_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      count_q     <= '0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bad_q       <= bad_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

endmodule
